// File: rtl/nn_pkg.sv
// Shared types and helpers for the classifier output layer.
// Holds default sizes, the sequencer state encoding and the score clamp.
package nn_pkg;

  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned N_OUT_DEF = 10;
  localparam int unsigned CLAMP_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_BIAS,
    ST_FIN,
    ST_DONE
  } state_t;

  // Saturate a signed value into the unsigned range [0, 2^dw-1].
  function automatic logic [CLAMP_W-1:0] clamp_u(input logic signed [CLAMP_W-1:0] x,
                                                 input int unsigned dw);
    logic signed [CLAMP_W-1:0] hi;
    hi = $signed((CLAMP_W'(1) << dw) - CLAMP_W'(1));
    if (x < 0) begin
      clamp_u = '0;
    end else if (x > hi) begin
      clamp_u = hi;
    end else begin
      clamp_u = x;
    end
  endfunction

  // Bit offset of score slot j inside the packed score bus.
  function automatic int unsigned slot_lsb(input int unsigned j, input int unsigned dw);
    slot_lsb = j * dw;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate: unsigned activation times signed weight.
// Synchronous clear has priority over enable.
module mac_unit #(
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic [DW-1:0]           a,
  input  logic signed [DW-1:0]    b,
  output logic signed [ACC_W-1:0] acc
);

  localparam int unsigned PW = 2 * DW + 1;

  logic signed [PW-1:0] prod_c;

  // Zero-extend the activation so it multiplies as a non-negative signed value.
  assign prod_c = PW'($signed({1'b0, a})) * PW'(b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod_c);
    end
  end

endmodule

// File: rtl/output_layer_mac.sv
// Sequential output-layer engine: one MAC per cycle over external memories,
// bias add, shift and clamp, then packs N_OUT unsigned scores onto a flat bus.
module output_layer_mac
  import nn_pkg::*;
#(
  parameter  int unsigned N_IN  = 64,
  parameter  int unsigned N_OUT = N_OUT_DEF,
  parameter  int unsigned DW    = DW_DEF,
  parameter  int unsigned ACC_W = 24,
  parameter  int unsigned SHIFT = 0,
  localparam int unsigned AW    = $clog2(N_IN),
  localparam int unsigned WAW   = $clog2(N_OUT * (N_IN + 1))
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       act_addr,
  input  logic [DW-1:0]       act_data,
  output logic [WAW-1:0]      w_addr,
  input  logic [DW-1:0]      w_data,
  output logic [N_OUT*DW-1:0] scores,
  output logic                scores_valid
);

  localparam int unsigned JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned SUM_W = ACC_W + 1;

  state_t                state, state_nx;
  logic [JW-1:0]         j_q, j_nx;
  logic [AW-1:0]         act_addr_nx;
  logic [WAW-1:0]        w_addr_nx;
  logic [N_OUT*DW-1:0]   scores_nx;
  logic                  valid_nx;
  logic                  busy_nx;
  logic                  done_nx;
  logic                  mac_clr_c;
  logic                  mac_en_c;
  logic signed [DW-1:0]  w_s;
  logic signed [ACC_W-1:0] acc;
  logic signed [SUM_W-1:0] sum_c;
  logic signed [SUM_W-1:0] shifted_c;
  logic [DW-1:0]         result_c;

  assign w_s = w_data;

  mac_unit #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr_c),
    .en    (mac_en_c),
    .a     (act_data),
    .b     (w_s),
    .acc   (acc)
  );

  // In FIN the bias word is on w_data and acc holds all N_IN products.
  always_comb begin
    sum_c     = SUM_W'(acc) + SUM_W'(w_s);
    shifted_c = sum_c >>> SHIFT;
    result_c  = DW'(clamp_u(CLAMP_W'(shifted_c), DW));
  end

  // Next-state, address sequencing and registered-output next values.
  always_comb begin
    state_nx    = state;
    j_nx        = j_q;
    act_addr_nx = act_addr;
    w_addr_nx   = w_addr;
    scores_nx   = scores;
    valid_nx    = scores_valid;
    mac_clr_c   = 1'b0;
    mac_en_c    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx    = ST_RUN;
          j_nx        = '0;
          act_addr_nx = '0;
          w_addr_nx   = '0;
          valid_nx    = 1'b0;
          mac_clr_c   = 1'b1;
        end
      end
      ST_RUN: begin
        // Data returned this cycle belongs to the previous address.
        mac_en_c  = (act_addr != '0);
        w_addr_nx = w_addr + WAW'(1);
        if (act_addr != AW'(N_IN - 1)) begin
          act_addr_nx = act_addr + AW'(1);
        end else begin
          state_nx = ST_BIAS;
        end
      end
      ST_BIAS: begin
        mac_en_c = 1'b1;
        state_nx = ST_FIN;
      end
      ST_FIN: begin
        scores_nx[slot_lsb(32'(j_q), DW) +: DW] = result_c;
        if (j_q != JW'(N_OUT - 1)) begin
          state_nx    = ST_RUN;
          j_nx        = j_q + JW'(1);
          act_addr_nx = '0;
          w_addr_nx   = w_addr + WAW'(1);
          mac_clr_c   = 1'b1;
        end else begin
          state_nx = ST_DONE;
          valid_nx = 1'b1;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    busy_nx = (state_nx != ST_IDLE);
    done_nx = (state_nx == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      j_q          <= '0;
      act_addr     <= '0;
      w_addr       <= '0;
      scores       <= '0;
      scores_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nx;
      j_q          <= j_nx;
      act_addr     <= act_addr_nx;
      w_addr       <= w_addr_nx;
      scores       <= scores_nx;
      scores_valid <= valid_nx;
      busy         <= busy_nx;
      done         <= done_nx;
    end
  end

endmodule

// File: tb/tb_output_layer_mac.sv
// Bench for output_layer_mac: two instances (SHIFT=0 and SHIFT=9) share one
// memory image; a scoreboard queue holds the expected score bus per pass.
module tb_output_layer_mac;

  localparam int unsigned N_IN  = 4;
  localparam int unsigned N_OUT = 10;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 2;
  localparam int unsigned WAW   = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic start;

  logic              busy0, done0, valid0, busy9, done9, valid9;
  logic [AW-1:0]     act_addr0, act_addr9;
  logic [WAW-1:0]    w_addr0, w_addr9;
  logic [DW-1:0]     act_data0, act_data9, w_data0, w_data9;
  logic [N_OUT*DW-1:0] scores0, scores9;

  logic [7:0] act_mem [0:N_IN-1];
  logic [7:0] w_mem   [0:N_OUT*(N_IN+1)-1];

  logic [N_OUT*DW-1:0] q0[$];
  logic [N_OUT*DW-1:0] q9[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  output_layer_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .ACC_W(24), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0), .done(done0),
    .act_addr(act_addr0), .act_data(act_data0), .w_addr(w_addr0), .w_data(w_data0),
    .scores(scores0), .scores_valid(valid0)
  );

  output_layer_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .ACC_W(24), .SHIFT(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy9), .done(done9),
    .act_addr(act_addr9), .act_data(act_data9), .w_addr(w_addr9), .w_data(w_data9),
    .scores(scores9), .scores_valid(valid9)
  );

  // Synchronous memories with one-cycle read latency.
  always @(posedge clk) begin
    act_data0 <= act_mem[act_addr0];
    w_data0   <= w_mem[w_addr0];
    act_data9 <= act_mem[act_addr9];
    w_data9   <= w_mem[w_addr9];
  end

  function automatic logic [N_OUT*DW-1:0] model(input int shift);
    logic [N_OUT*DW-1:0] v;
    int s;
    v = '0;
    for (int j = 0; j < int'(N_OUT); j++) begin
      s = 0;
      for (int i = 0; i < int'(N_IN); i++)
        s += int'(act_mem[i]) * int'($signed(w_mem[j*5+i]));
      s += int'($signed(w_mem[j*5+4]));
      s = s >>> shift;
      if (s < 0) s = 0;
      else if (s > 255) s = 255;
      v[j*8 +: 8] = 8'(s);
    end
    return v;
  endfunction

  task automatic set_mem(input int kind);
    int w;
    for (int i = 0; i < int'(N_IN); i++) begin
      case (kind)
        0: act_mem[i] = 8'd1;
        1: act_mem[i] = 8'd10;
        2: act_mem[i] = 8'd255;
        3: act_mem[i] = 8'(i + 1);
        4: act_mem[i] = 8'd2;
        default: act_mem[i] = 8'(17 * i + 3);
      endcase
    end
    for (int j = 0; j < int'(N_OUT); j++) begin
      for (int i = 0; i < 5; i++) begin
        case (kind)
          0: w = (i == 4) ? 0 : j;
          1: w = (i == 4) ? 5 : -1;
          2: w = 127;
          3: w = (i == 4) ? j : j - 3;
          4: w = (i == 4) ? -j : 5 - j;
          default: w = (i == 4) ? 2 * j : ((i + j) % 7) - 3;
        endcase
        w_mem[j*5+i] = 8'(w);
      end
    end
  endtask

  // Drive a one-cycle start and record the expected result; returns in cycle 1.
  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    q0.push_back(model(0));
    q9.push_back(model(9));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (done0 !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Scoreboard: compare both score buses whenever a pass finishes.
  always @(negedge clk) begin
    logic [N_OUT*DW-1:0] e0, e9;
    if (rst_n === 1'b1 && done0 === 1'b1) begin
      total++;
      if (done9 !== 1'b1) begin
        bad++;
        $display("FAIL sb_done9: got %b want 1", done9);
      end
      total++;
      if (q0.size() == 0 || q9.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: got done with %0d queued want >=1", q0.size());
      end else begin
        e0 = q0.pop_front();
        e9 = q9.pop_front();
        if (scores0 !== e0) begin
          bad++;
          $display("FAIL sb_scores_shift0: got %h want %h", scores0, e0);
        end
        total++;
        if (scores9 !== e9) begin
          bad++;
          $display("FAIL sb_scores_shift9: got %h want %h", scores9, e9);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    set_mem(0);
    repeat (2) @(negedge clk);
    total += 6;
    if (busy0 !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy0); end
    if (done0 !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done0); end
    if (valid0 !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", valid0); end
    if (scores0 !== '0) begin bad++; $display("FAIL rst_scores: got %h want 0", scores0); end
    if (act_addr0 !== '0) begin bad++; $display("FAIL rst_act_addr: got %h want 0", act_addr0); end
    if (w_addr0 !== '0) begin bad++; $display("FAIL rst_w_addr: got %h want 0", w_addr0); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    int cyc;
    int best;
    set_mem(0);
    kick();
    total++;
    if (busy0 !== 1'b1) begin bad++; $display("FAIL ramp_busy_c1: got %b want 1", busy0); end
    wait_done(1, cyc);
    total++;
    if (cyc != 61) begin bad++; $display("FAIL ramp_done_cycle: got %0d want 61", cyc); end
    total++;
    if (scores0[72 +: 8] !== 8'd36) begin bad++; $display("FAIL ramp_slot9: got %0d want 36", scores0[72 +: 8]); end
    best = 0;
    for (int k = 1; k < int'(N_OUT); k++)
      if (scores0[k*8 +: 8] > scores0[best*8 +: 8]) best = k;
    total++;
    if (best != 9) begin bad++; $display("FAIL ramp_argmax: got %0d want 9", best); end
    @(negedge clk);
    total += 3;
    if (busy0 !== 1'b0) begin bad++; $display("FAIL ramp_busy_after: got %b want 0", busy0); end
    if (done0 !== 1'b0) begin bad++; $display("FAIL ramp_done_width: got %b want 0", done0); end
    if (valid0 !== 1'b1) begin bad++; $display("FAIL ramp_valid_after: got %b want 1", valid0); end
  endtask

  task automatic test_clamp_low();
    int cyc;
    set_mem(1);
    kick();
    wait_done(1, cyc);
    total += 3;
    if (cyc != 61) begin bad++; $display("FAIL neg_done_cycle: got %0d want 61", cyc); end
    if (valid0 !== 1'b1) begin bad++; $display("FAIL neg_valid: got %b want 1", valid0); end
    if (scores0 !== '0) begin bad++; $display("FAIL neg_scores: got %h want 0", scores0); end
    @(negedge clk);
  endtask

  task automatic test_clamp_high();
    int cyc;
    set_mem(2);
    kick();
    wait_done(1, cyc);
    total += 3;
    if (cyc != 61) begin bad++; $display("FAIL sat_done_cycle: got %0d want 61", cyc); end
    if (scores0[7:0] !== 8'd255) begin bad++; $display("FAIL sat_shift0: got %0d want 255", scores0[7:0]); end
    if (scores9[7:0] !== 8'd253) begin bad++; $display("FAIL sat_shift9: got %0d want 253", scores9[7:0]); end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int cyc;
    int dones;
    int gaps;
    logic busy62;
    set_mem(5);
    kick();
    cyc = 1;
    dones = 0;
    gaps = 0;
    busy62 = 1'bx;
    while (cyc <= 70) begin
      if (done0 === 1'b1) dones++;
      if (cyc <= 61 && busy0 !== 1'b1) gaps++;
      if (cyc == 62) busy62 = busy0;
      start = (cyc == 5 || cyc == 61);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    total += 3;
    if (dones != 1) begin bad++; $display("FAIL ign_done_count: got %0d want 1", dones); end
    if (gaps != 0) begin bad++; $display("FAIL ign_busy_gaps: got %0d want 0", gaps); end
    if (busy62 !== 1'b0) begin bad++; $display("FAIL ign_busy_c62: got %b want 0", busy62); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    set_mem(3);
    kick();
    wait_done(1, cyc);
    @(negedge clk);
    set_mem(5);
    kick();
    cyc = 1;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    q0.delete();
    q9.delete();
    total += 4;
    if (busy0 !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy0); end
    if (done0 !== 1'b0) begin bad++; $display("FAIL mid_done: got %b want 0", done0); end
    if (scores0 !== '0) begin bad++; $display("FAIL mid_scores: got %h want 0", scores0); end
    if (valid0 !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", valid0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_mem(4);
    kick();
    wait_done(1, cyc);
    total++;
    if (cyc != 61) begin bad++; $display("FAIL mid_clean_done: got %0d want 61", cyc); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [N_OUT*DW-1:0] exp_a, exp_b;
    set_mem(3);
    exp_a = model(0);
    kick();
    wait_done(1, cyc);
    set_mem(4);
    exp_b = model(0);
    @(negedge clk);
    total += 2;
    if (valid0 !== 1'b1) begin bad++; $display("FAIL b2b_valid_idle: got %b want 1", valid0); end
    if (busy0 !== 1'b0) begin bad++; $display("FAIL b2b_busy_idle: got %b want 0", busy0); end
    start = 1'b1;
    q0.push_back(exp_b);
    q9.push_back(model(9));
    @(negedge clk);
    start = 1'b0;
    total += 2;
    if (valid0 !== 1'b0) begin bad++; $display("FAIL b2b_valid_drop: got %b want 0", valid0); end
    if (busy0 !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", busy0); end
    cyc = 1;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    total += 2;
    if (scores0[72 +: 8] !== exp_a[72 +: 8]) begin
      bad++; $display("FAIL b2b_slot9_kept: got %0d want %0d", scores0[72 +: 8], exp_a[72 +: 8]);
    end
    if (scores0[7:0] !== exp_b[7:0]) begin
      bad++; $display("FAIL b2b_slot0_new: got %0d want %0d", scores0[7:0], exp_b[7:0]);
    end
    wait_done(20, cyc);
    total++;
    if (cyc != 61) begin bad++; $display("FAIL b2b_done_cycle: got %0d want 61", cyc); end
    @(negedge clk);
    total++;
    if (q0.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d want 0", q0.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ramp();
    test_clamp_low();
    test_clamp_high();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
